demo_sequencer: RTL and testbench
=================================

Name: demo_sequencer

Overview:
- Parametrised song player for the synth demo path.
- Fetches one step per tempo period from a synchronous song ROM (NUM_VOICES packed 16-bit voice entries).
- Decodes each voice into pitch, waveform and volume-weighted channel enables on the NUM-channel oscillator bank, with all outputs registered.
- Adds play/stop, pause, loop and end-of-song control, a runtime tempo and an internal prescaler, so no external clock divider is needed.

Parameters:
- SONG_LENGTH, 128: number of ROM entries; rom_addr width is $clog2(SONG_LENGTH).
- TICK_DIVIDE, 100: clk cycles per tempo tick; must be ≥1.
- ROM_LATENCY, 1: cycles from rom_addr change to valid rom_data; must be ≥1.
- NUM_VOICES, 6: voices per ROM entry.
- CPV, 4: channels per voice.
- NUM, 25: oscillator channels. NUM ≥ NUM_VOICES*CPV is required; elaboration error otherwise.
- C, 12: pitch width per channel; voice pitch field is 12 bits, zero-extended or truncated to C.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- play  in  1  level: 1 = run, 0 = stop and rewind
- pause  in  1  level: freezes step timing and holds outputs
- loop  in  1  restart at address 0 after last entry or end marker
- tempo_div  in  8  ticks per step, sampled on entry to HOLD; 0 is treated as 1
- rom_addr  out  $clog2(SONG_LENGTH)  song ROM address
- rom_data  in  NUM_VOICES*16  ROM word; voice v = rom_data[v*16 +: 16], with pitch [15:4], vol [3:2], wave [1:0]
- pitches  out  NUM*C  per-channel pitch
- waveforms  out  NUM*2  per-channel waveform select
- channel_ena  out  NUM  per-channel enable
- playing  out  1  high in FETCH and HOLD
- step  out  1  one-cycle pulse when outputs load a new entry
- song_done  out  1  one-cycle pulse on entering DONE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State IDLE.
  - rom_addr, pitches, waveforms, channel_ena, playing, step, song_done all 0.
  - Prescaler and tick counters cleared.
- States: IDLE, FETCH, HOLD, DONE.
- IDLE:
  - Outputs 0, rom_addr 0.
  - play=1 moves to FETCH on the next edge.
- FETCH:
  - rom_addr held for exactly ROM_LATENCY cycles.
  - rom_data is sampled at the edge ending the last FETCH cycle.
  - End marker (voice 0 field == 16'hFFFF):
    - loop=1 and rom_addr≠0: rom_addr←0, re-enter FETCH, outputs unchanged.
    - Otherwise: go to DONE, outputs←0, song_done pulses.
  - Any other entry:
    - Decode into output registers and pulse step.
    - Latch max(tempo_div,1), clear prescaler, go to HOLD.
- Decode for voice v:
  - Channels v*CPV .. v*CPV+CPV-1 receive that voice's pitch and wave.
  - vol code sets enables on the voice's lowest channels: 0 → none; 1 → lowest 1; 2 → lowest ceil(CPV/2); 3 → all CPV.
  - Channels ≥ NUM_VOICES*CPV are always 0.
- HOLD:
  - Lasts exactly latched_tempo*TICK_DIVIDE cycles, then leaves on the next edge:
    - rom_addr < SONG_LENGTH-1: rom_addr+1, go to FETCH.
    - rom_addr == SONG_LENGTH-1 and loop=1: rom_addr←0, go to FETCH.
    - rom_addr == SONG_LENGTH-1 and loop=0: go to DONE, outputs←0, song_done pulses.
  - Outputs are stable throughout HOLD.
  - Step period = ROM_LATENCY + tempo*TICK_DIVIDE cycles.
- DONE:
  - Outputs 0, playing 0.
  - Stays until play=0, then goes to IDLE. play held high does not restart.
- pause=1:
  - In HOLD: prescaler and tick counter freeze; outputs, state and rom_addr hold. Counting resumes with no lost or extra cycles.
  - In FETCH: FETCH completes and HOLD is entered but frozen.
  - No effect in IDLE or DONE.
- play=0 in FETCH or HOLD (including while paused): next edge → IDLE, all outputs 0, rom_addr 0. This is a stop, not a pause.
- Priority: reset > play=0 > pause > normal sequencing.
- step and song_done are never asserted in the same cycle.
- Changing tempo_div mid-HOLD has no effect until the next HOLD.

Test Plan:
- Reset/start (TICK_DIVIDE=4, ROM_LATENCY=1, tempo_div=2, loop=0): rst_n low then play=1 → step pulses every 9 cycles; rom_addr runs 0,1,2…; first step 2 cycles after play rises.
- Decode (NUM_VOICES=6, CPV=4): voice 0 word 16'h1239 (vol 2, wave 1) → pitches ch0–3 = 12'h123, waveforms ch0–3 = 2'b01, channel_ena[3:0] = 4'b0011; voice 1 vol 3 → channel_ena[7:4] = 4'b1111; channel_ena[24] = 0.
- End and loop (SONG_LENGTH=4): loop=0 → after addr 3 HOLD, song_done pulses once, outputs 0, state DONE while play=1. loop=1 → addr wraps 3→0 with no gap beyond FETCH. End marker at addr 2 with loop=1 → addr 0; marker at addr 0 → DONE.
- Pause: pause=1 for 20 cycles mid-HOLD → next step is delayed by exactly 20 cycles, outputs unchanged throughout.
- Stop: play=0 mid-HOLD → next cycle all outputs 0, rom_addr 0; play=1 again → replays from addr 0.
- Reset mid-play: rst_n=0 during FETCH with tempo_div=0 → all outputs 0. After release, each step lasts 1 + 1*TICK_DIVIDE cycles.

Source files
------------

// File: rtl/demo_sequencer.sv
// demo_sequencer: tempo-driven song player that decodes ROM steps onto an oscillator bank
//   clk, rst_n            clock, synchronous active-low reset
//   play, pause, loop     transport levels (stop-and-rewind, freeze, wrap at end)
//   tempo_div             ticks per step, latched each time a step loads (0 acts as 1)
//   rom_addr, rom_data    song ROM interface, NUM_VOICES packed 16-bit voices per word
//   pitches, waveforms, channel_ena  registered per-channel oscillator controls
//   playing, step, song_done         status (step/song_done are one-cycle pulses)
module demo_sequencer #(
  parameter int SONG_LENGTH = 128,
  parameter int TICK_DIVIDE = 100,
  parameter int ROM_LATENCY = 1,
  parameter int NUM_VOICES = 6,
  parameter int CPV = 4,
  parameter int NUM = 25,
  parameter int C = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           play,
  input  logic                           pause,
  input  logic                           loop,
  input  logic [7:0]                     tempo_div,
  output logic [$clog2(SONG_LENGTH)-1:0] rom_addr,
  input  logic [NUM_VOICES*16-1:0]       rom_data,
  output logic [NUM*C-1:0]               pitches,
  output logic [NUM*2-1:0]               waveforms,
  output logic [NUM-1:0]                 channel_ena,
  output logic                           playing,
  output logic                           step,
  output logic                           song_done
);
  localparam int AW = $clog2(SONG_LENGTH);
  localparam int NCH = NUM_VOICES * CPV;
  localparam int HALF = (CPV + 1) / 2;
  localparam int PW = TICK_DIVIDE > 1 ? $clog2(TICK_DIVIDE) : 1;
  localparam int FW = ROM_LATENCY > 1 ? $clog2(ROM_LATENCY) : 1;
  localparam logic [AW-1:0] LAST = AW'(SONG_LENGTH - 1);

  if (NUM < NCH) begin : g_bad_num
    $error("demo_sequencer: NUM must be at least NUM_VOICES*CPV");
  end
  if (TICK_DIVIDE < 1 || ROM_LATENCY < 1) begin : g_bad_timing
    $error("demo_sequencer: TICK_DIVIDE and ROM_LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t state, state_n;
  logic [AW-1:0] addr_n;
  logic [PW-1:0] pre;
  logic [7:0] tick, tempo;
  logic [FW-1:0] fcnt;
  logic load, clr, fin;
  logic fetch_last, pre_wrap, hold_last, marker, addr_last;
  logic [NUM*C-1:0] dec_pitch;
  logic [NUM*2-1:0] dec_wave;
  logic [NUM-1:0] dec_ena;

  assign fetch_last = fcnt == FW'(ROM_LATENCY - 1);
  assign pre_wrap = pre == PW'(TICK_DIVIDE - 1);
  // HOLD spans tempo ticks of TICK_DIVIDE cycles; this is its final cycle
  assign hold_last = pre_wrap && tick == tempo - 8'd1;
  assign marker = rom_data[15:0] == 16'hFFFF;
  assign addr_last = rom_addr == LAST;

  for (genvar i = 0; i < NUM; i++) begin : g_ch
    if (i < NCH) begin : g_v
      localparam int V = i / CPV;
      localparam int K = i % CPV;
      localparam logic L1 = K < 1;
      localparam logic L2 = K < HALF;
      logic [15:0] w;
      assign w = rom_data[V*16 +: 16];
      assign dec_pitch[i*C +: C] = C'(w[15:4]);
      assign dec_wave[i*2 +: 2] = w[1:0];
      // vol 1 lights the lowest channel, vol 2 the lower half (rounded up), vol 3 all
      assign dec_ena[i] = (w[3:2] == 2'd3) | (w[3:2] == 2'd2 & L2) | (w[3:2] == 2'd1 & L1);
    end else begin : g_z
      assign dec_pitch[i*C +: C] = '0;
      assign dec_wave[i*2 +: 2] = '0;
      assign dec_ena[i] = 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    addr_n = rom_addr;
    load = 1'b0;
    clr = 1'b0;
    fin = 1'b0;
    if (!play) begin
      state_n = IDLE;
      addr_n = '0;
      clr = 1'b1;
    end else begin
      case (state)
        IDLE: state_n = FETCH;
        FETCH: if (fetch_last) begin
          if (!marker) begin
            state_n = HOLD;
            load = 1'b1;
          end else if (loop && rom_addr != '0) begin
            addr_n = '0;
          end else begin
            state_n = DONE;
            addr_n = '0;
            clr = 1'b1;
            fin = 1'b1;
          end
        end
        HOLD: if (!pause && hold_last) begin
          if (!addr_last || loop) begin
            state_n = FETCH;
            addr_n = addr_last ? '0 : rom_addr + AW'(1);
          end else begin
            state_n = DONE;
            addr_n = '0;
            clr = 1'b1;
            fin = 1'b1;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rom_addr <= '0;
    end else begin
      state <= state_n;
      rom_addr <= addr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
      tick <= '0;
      tempo <= 8'd1;
      fcnt <= '0;
      pitches <= '0;
      waveforms <= '0;
      channel_ena <= '0;
      playing <= 1'b0;
      step <= 1'b0;
      song_done <= 1'b0;
    end else begin
      fcnt <= (state == FETCH && state_n == FETCH && !fetch_last) ? fcnt + FW'(1) : '0;
      step <= load;
      song_done <= fin;
      playing <= state_n == FETCH || state_n == HOLD;
      if (load) begin
        tempo <= (tempo_div == 8'd0) ? 8'd1 : tempo_div;
        pre <= '0;
        tick <= '0;
      end else if (state == HOLD && !pause) begin
        pre <= pre_wrap ? '0 : pre + PW'(1);
        tick <= pre_wrap ? tick + 8'd1 : tick;
      end
      if (load) begin
        pitches <= dec_pitch;
        waveforms <= dec_wave;
        channel_ena <= dec_ena;
      end else if (clr) begin
        pitches <= '0;
        waveforms <= '0;
        channel_ena <= '0;
      end
    end
  end
endmodule

// File: tb/tb_demo_sequencer.sv
// tb_demo_sequencer: directed and random stimulus for demo_sequencer checked against a step-level model
module tb_demo_sequencer;
  localparam int SL = 4;
  localparam int TD = 4;
  localparam int RL = 1;
  localparam int NV = 6;
  localparam int CPV = 4;
  localparam int NUM = 25;
  localparam int C = 12;
  localparam int MI = 0, MF = 1, MH = 2, MD = 3;

  logic clk = 1'b0;
  logic rst_n, play, pause, loop;
  logic [7:0] tempo_div;
  logic [1:0] rom_addr;
  logic [NV*16-1:0] rom_data;
  logic [NUM*C-1:0] pitches;
  logic [NUM*2-1:0] waveforms;
  logic [NUM-1:0] channel_ena;
  logic playing, step, song_done;

  logic [NV*16-1:0] rom [SL];
  int compared = 0;
  int failed = 0;

  int m_mode, m_addr, m_fleft, m_hleft;
  logic [NUM*C-1:0] e_pitch;
  logic [NUM*2-1:0] e_wave;
  logic [NUM-1:0] e_ena;
  logic e_step, e_done;

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  demo_sequencer #(
    .SONG_LENGTH(SL), .TICK_DIVIDE(TD), .ROM_LATENCY(RL),
    .NUM_VOICES(NV), .CPV(CPV), .NUM(NUM), .C(C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .pause(pause), .loop(loop),
    .tempo_div(tempo_div), .rom_addr(rom_addr), .rom_data(rom_data),
    .pitches(pitches), .waveforms(waveforms), .channel_ena(channel_ena),
    .playing(playing), .step(step), .song_done(song_done)
  );

  task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NV*16-1:0] rnd_word(input bit mk);
    logic [NV*16-1:0] w;
    for (int i = 0; i < NV; i++) w[i*16 +: 16] = 16'($urandom);
    if (mk && $urandom_range(0, 5) == 0) w[15:0] = 16'hFFFF;
    else if (w[15:0] == 16'hFFFF) w[0] = 1'b0;
    return w;
  endfunction

  task automatic clear_expect();
    e_pitch = '0;
    e_wave = '0;
    e_ena = '0;
  endtask

  // Voice v drives channels v*CPV.. with its pitch and wave; vol picks how many low channels light
  task automatic load_expect(input logic [NV*16-1:0] w);
    for (int ch = 0; ch < NUM; ch++) begin
      logic [15:0] v;
      int n;
      int vi;
      vi = ch / CPV;
      v = (vi < NV) ? w[vi*16 +: 16] : 16'h0;
      n = (v[3:2] == 2'd0) ? 0 : (v[3:2] == 2'd1) ? 1 : (v[3:2] == 2'd2) ? (CPV + 1) / 2 : CPV;
      e_pitch[ch*C +: C] = v[15:4];
      e_wave[ch*2 +: 2] = v[1:0];
      e_ena[ch] = (ch % CPV) < n;
    end
  endtask

  task automatic finish_song();
    m_mode = MD;
    m_addr = 0;
    clear_expect();
    e_done = 1'b1;
  endtask

  task automatic model_edge();
    logic [NV*16-1:0] w;
    e_step = 1'b0;
    e_done = 1'b0;
    if (!rst_n || !play) begin
      m_mode = MI;
      m_addr = 0;
      clear_expect();
    end else if (m_mode == MI) begin
      m_mode = MF;
      m_fleft = RL;
    end else if (m_mode == MF) begin
      m_fleft--;
      if (m_fleft == 0) begin
        w = rom[m_addr];
        if (w[15:0] != 16'hFFFF) begin
          load_expect(w);
          e_step = 1'b1;
          m_hleft = (tempo_div == 8'd0 ? 1 : int'(tempo_div)) * TD;
          m_mode = MH;
        end else if (loop && m_addr != 0) begin
          m_addr = 0;
          m_fleft = RL;
        end else finish_song();
      end
    end else if (m_mode == MH && !pause) begin
      m_hleft--;
      if (m_hleft == 0) begin
        if (m_addr < SL - 1 || loop) begin
          m_addr = (m_addr < SL - 1) ? m_addr + 1 : 0;
          m_mode = MF;
          m_fleft = RL;
        end else finish_song();
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("rom_addr", rom_addr, m_addr);
    check("pitches", pitches, e_pitch);
    check("waveforms", waveforms, e_wave);
    check("channel_ena", channel_ena, e_ena);
    check("playing", playing, m_mode == MF || m_mode == MH);
    check("step", step, e_step);
    check("song_done", song_done, e_done);
  endtask

  task automatic wait_step(input string tag, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < 300);
    check(tag, step, 1'b1);
  endtask

  initial begin
    int n, n2, dn;
    rst_n = 1'b0; play = 1'b0; pause = 1'b0; loop = 1'b0; tempo_div = 8'd2;
    m_mode = MI; m_addr = 0; m_fleft = 0; m_hleft = 0;
    e_step = 1'b0; e_done = 1'b0;
    clear_expect();
    for (int i = 0; i < SL; i++) rom[i] = rnd_word(1'b0);
    rom[0][31:0] = 32'hABCE_1239;
    repeat (3) cyc();
    check("reset_addr", rom_addr, 0);
    check("reset_ena", channel_ena, 0);
    check("reset_playing", playing, 0);
    rst_n = 1'b1;
    cyc();
    play = 1'b1;
    wait_step("wait_first", n);
    check("first_step_latency", n, 2);
    check("dec_pitch_v0", pitches[47:0], {4{12'h123}});
    check("dec_wave_v0", waveforms[7:0], 8'b0101_0101);
    check("dec_ena_v0", channel_ena[3:0], 4'b0011);
    check("dec_ena_v1", channel_ena[7:4], 4'b1111);
    check("dec_ena_spare", channel_ena[24], 1'b0);
    for (int k = 1; k < SL; k++) begin
      wait_step("wait_seq", n);
      check("step_period", n, 9);
      check("seq_addr", rom_addr, k);
    end
    dn = 0;
    repeat (20) begin
      cyc();
      dn += int'(song_done);
    end
    check("done_once", dn, 1);
    check("done_playing", playing, 1'b0);
    check("done_ena", channel_ena, 0);
    play = 1'b0;
    repeat (2) cyc();
    loop = 1'b1;
    play = 1'b1;
    wait_step("wait_loop_first", n);
    check("loop_first_latency", n, 2);
    for (int k = 0; k < SL; k++) begin
      wait_step("wait_loop", n);
      check("loop_period", n, 9);
    end
    check("loop_wrap_addr", rom_addr, 0);
    wait_step("wait_pause", n);
    repeat (3) cyc();
    pause = 1'b1;
    repeat (20) cyc();
    pause = 1'b0;
    wait_step("wait_after_pause", n2);
    check("pause_period", n2 + 23, 29);
    wait_step("wait_stop", n);
    repeat (4) cyc();
    play = 1'b0;
    cyc();
    check("stop_addr", rom_addr, 0);
    check("stop_pitches", pitches, 0);
    check("stop_playing", playing, 1'b0);
    play = 1'b1;
    wait_step("wait_replay", n);
    check("replay_latency", n, 2);
    check("replay_addr", rom_addr, 0);
    play = 1'b0;
    cyc();
    rom[2][15:0] = 16'hFFFF;
    play = 1'b1;
    wait_step("wait_mk0", n);
    wait_step("wait_mk1", n);
    wait_step("wait_mk_wrap", n);
    check("marker_wrap_period", n, 10);
    check("marker_wrap_addr", rom_addr, 0);
    play = 1'b0;
    cyc();
    rom[0][15:0] = 16'hFFFF;
    play = 1'b1;
    repeat (2) cyc();
    check("marker0_done", song_done, 1'b1);
    check("marker0_playing", playing, 1'b0);
    cyc();
    check("marker0_done_pulse", song_done, 1'b0);
    play = 1'b0;
    cyc();
    for (int i = 0; i < SL; i++) rom[i] = rnd_word(1'b1);
    for (int i = 0; i < 2500; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (!play) begin
        if (r < 300) play = 1'b1;
        if (r < 60) rom[$urandom_range(0, SL - 1)] = rnd_word(1'b1);
      end else if (r < 8) play = 1'b0;
      if (pause) begin
        if ($urandom_range(0, 9) == 0) pause = 1'b0;
      end else if ($urandom_range(0, 59) == 0) pause = 1'b1;
      if ($urandom_range(0, 29) == 0) loop = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) tempo_div = 8'($urandom_range(0, 3));
      cyc();
    end
    pause = 1'b0;
    loop = 1'b1;
    play = 1'b0;
    for (int i = 0; i < SL; i++) rom[i] = rnd_word(1'b0);
    cyc();
    play = 1'b1;
    tempo_div = 8'd0;
    cyc();
    rst_n = 1'b0;
    cyc();
    check("midreset_addr", rom_addr, 0);
    check("midreset_pitches", pitches, 0);
    check("midreset_playing", playing, 1'b0);
    rst_n = 1'b1;
    wait_step("wait_post_reset", n);
    check("post_reset_latency", n, 2);
    repeat (2) begin
      wait_step("wait_fast", n);
      check("fast_period", n, 1 + TD);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
